// File: rtl/nonce_result_queue_if.sv
// rtl/nonce_result_queue_if.sv - nonce ingress and transmitter handshake bundle for nonce_result_queue.
// master: the queue itself; slave: hashing cores, transmitter and status observers.
interface nonce_result_queue_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  nonce_valid;
  logic [31:0]           nonce;
  logic                  tx_busy;
  logic                  tx_send;
  logic [31:0]           tx_word;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;

  modport master (
    input  nonce_valid, nonce, tx_busy,
    output tx_send, tx_word, count, overflow
  );

  modport slave (
    output nonce_valid, nonce, tx_busy,
    input  tx_send, tx_word, count, overflow
  );
endinterface

// File: rtl/nonce_result_queue.sv
// rtl/nonce_result_queue.sv - golden-nonce FIFO drained to a serial transmitter by a send/ack FSM.
// Optional CONFIG_NONCE_DEDUP_EN drops a nonce equal to the most recently accepted one.
module nonce_result_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nonce_result_queue_if.master  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WCW   = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_e;

  state_e              state_q;
  logic [31:0]         mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic                tx_send_q;
  logic [31:0]         tx_word_q;
  logic [WCW-1:0]      wait_cnt_q;
  logic                empty, full, pop, push, dup;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  // A pop on the same edge frees the slot, so a push at full still lands.
  assign pop   = (state_q == WAIT_BUSY) && bus.tx_busy;
  assign push  = bus.nonce_valid && !dup && (!full || pop);

`ifdef CONFIG_NONCE_DEDUP_EN
  logic [31:0] last_q;
  logic        last_vld_q;

  assign dup = last_vld_q && (bus.nonce == last_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= bus.nonce;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q | (bus.nonce_valid && !dup && full && !pop);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.nonce;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // The head entry stays queued until the transmitter acknowledges with busy,
  // so an ignored request simply times out and the same word is offered again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_send_q  <= 1'b0;
      tx_word_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      tx_send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empty && !bus.tx_busy) begin
            state_q   <= SEND;
            tx_send_q <= 1'b1;
            tx_word_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
          end
        end
        SEND: begin
          state_q    <= WAIT_BUSY;
          wait_cnt_q <= '0;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (wait_cnt_q == WCW'(WAIT_LIMIT - 1)) begin
            state_q <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_send  = tx_send_q;
  assign bus.tx_word  = tx_word_q;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_nonce_result_queue.sv
// tb/tb_nonce_result_queue.sv - directed self-checking bench for nonce_result_queue.
// Transmitter model raises busy one cycle after each send request for busy_len cycles.
module tb_nonce_result_queue;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic        model_en;
  logic        hold_busy;
  int          busy_len;
  int          busy_left = 0;
  logic        delay_pend = 1'b0;
  logic [31:0] sent_q [$];
  int          send_cyc [$];

  nonce_result_queue_if #(.DEPTH_LOG2(3)) bus ();

  nonce_result_queue #(.DEPTH_LOG2(3), .WAIT_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!model_en) begin
      bus.tx_busy = hold_busy;
      delay_pend  = 1'b0;
      busy_left   = 0;
    end else begin
      if (delay_pend) begin
        busy_left  = busy_len;
        delay_pend = 1'b0;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      bus.tx_busy = (busy_left > 0);
      if (bus.tx_send) delay_pend = 1'b1;
    end
    if (bus.tx_send) begin
      sent_q.push_back(bus.tx_word);
      send_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    sent_q.delete();
    send_cyc.delete();
  endtask

  function automatic logic [31:0] word_at(input int i);
    if (sent_q.size() > i) return sent_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic int cyc_at(input int i);
    if (send_cyc.size() > i) return send_cyc[i];
    return -1000;
  endfunction

  task automatic wait_sent(input string tag, input int n, input int budget);
    int b = budget;
    while (sent_q.size() < n && b > 0) begin
      tick();
      b--;
    end
    check(tag, sent_q.size(), n);
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.nonce_valid = 1'b1;
    bus.nonce       = w;
    tick();
    bus.nonce_valid = 1'b0;
  endtask

  initial begin
    int c0;
    int b;
    bus.nonce_valid = 1'b0;
    bus.nonce       = '0;
    model_en        = 1'b0;
    hold_busy       = 1'b0;
    busy_len        = 3;

    // reset wins over a simultaneous nonce
    reset           = 1'b1;
    bus.nonce_valid = 1'b1;
    bus.nonce       = 32'h55;
    tick();
    tick();
    reset           = 1'b0;
    bus.nonce_valid = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_tx_send", bus.tx_send, 0);
    check("rst_tx_word", bus.tx_word, 0);
    repeat (4) tick();
    check("rst_nonce_dropped", bus.count, 0);
    check("rst_no_send", sent_q.size(), 0);

    // single nonce latency and drain
    model_en = 1'b1;
    busy_len = 40;
    do_reset();
    c0 = cyc;
    push_word(32'hDEADBEEF);
    wait_sent("t1_send", 1, 10);
    check("t1_latency", cyc_at(0) - c0, 2);
    check("t1_word", word_at(0), 32'hDEADBEEF);
    b = 100;
    while (bus.count != 0 && b > 0) begin
      tick();
      b--;
    end
    check("t1_count_zero", bus.count, 0);
    repeat (45) tick();
    check("t1_one_send", sent_q.size(), 1);

    // overflow with busy held, then in-order drain
    model_en  = 1'b0;
    hold_busy = 1'b1;
    busy_len  = 3;
    do_reset();
    for (int i = 1; i <= 9; i++) push_word(i);
    tick();
    check("t2_count_full", bus.count, 8);
    check("t2_overflow", bus.overflow, 1);
    check("t2_no_send", sent_q.size(), 0);
    model_en = 1'b1;
    wait_sent("t2_drain", 8, 300);
    repeat (40) tick();
    check("t2_total_sent", sent_q.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_word%0d", i), word_at(i), i + 1);
    check("t2_count_empty", bus.count, 0);
    check("t2_overflow_sticky", bus.overflow, 1);

    // push on the same edge as the pop while full
    model_en  = 1'b0;
    hold_busy = 1'b1;
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(i);
    tick();
    check("t3_count_full", bus.count, 8);
    model_en = 1'b1;
    tick();
    tick();
    push_word(32'h99);
    check("t3_count_held", bus.count, 8);
    check("t3_overflow", bus.overflow, 0);
    wait_sent("t3_drain", 9, 300);
    for (int i = 0; i < 8; i++) check($sformatf("t3_word%0d", i), word_at(i), i + 1);
    check("t3_last_word", word_at(8), 32'h99);

    // transmitter ignores the request: timeout and retry of the same word
    model_en  = 1'b0;
    hold_busy = 1'b1;
    do_reset();
    push_word(32'h77);
    tick();
    hold_busy = 1'b0;
    wait_sent("t4_retry", 2, 100);
    check("t4_retry_gap", cyc_at(1) - cyc_at(0), 18);
    check("t4_word0", word_at(0), 32'h77);
    check("t4_word1", word_at(1), 32'h77);
    check("t4_count", bus.count, 1);

    // duplicate nonces
    hold_busy = 1'b0;
    model_en  = 1'b1;
    busy_len  = 3;
    do_reset();
    push_word(32'hA);
    push_word(32'hA);
    push_word(32'hB);
    repeat (60) tick();
`ifdef CONFIG_NONCE_DEDUP_EN
    check("t5_sent", sent_q.size(), 2);
`else
    check("t5_sent", sent_q.size(), 3);
`endif
    check("t5_first", word_at(0), 32'hA);
    check("t5_last", word_at(sent_q.size() - 1), 32'hB);
    check("t5_overflow", bus.overflow, 0);

    // reset while waiting for the transmitter to finish
    busy_len = 20;
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(i);
    wait_sent("t6_first", 1, 20);
    repeat (4) tick();
    check("t6_pre_count", bus.count, 3);
    do_reset();
    check("t6_count", bus.count, 0);
    check("t6_overflow", bus.overflow, 0);
    repeat (60) tick();
    check("t6_no_send", sent_q.size(), 0);
    check("t6_count_after", bus.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nonce_result_queue.md
NONCE_RESULT_QUEUE -- requirements
Module: nonce_result_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, FIFO depth = 2**DEPTH_LOG2 entries (legal 1..6).
REQ-002 SHALL have parameter WAIT_LIMIT, default 16, max cycles in WAIT_BUSY before abandoning the handshake.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high.
REQ-005 SHALL have port nonce_valid  input  1  one-cycle strobe: a hashing core found a golden nonce.
REQ-006 SHALL have port nonce  input  32  golden nonce, valid with nonce_valid.
REQ-007 SHALL have port tx_busy  input  1  busy from the serial transmitter.
REQ-008 SHALL have port tx_send  output  1  one-cycle send request to the transmitter.
REQ-009 SHALL have port tx_word  output  32  word to transmit; stable while tx_send is high.
REQ-010 SHALL have port count  output  DEPTH_LOG2+1  current occupancy.
REQ-011 SHALL have port overflow  output  1  sticky: at least one nonce dropped since reset.

Function
REQ-012 SHALL store nonces in a circular FIFO with wr_ptr/rd_ptr one bit wider than DEPTH_LOG2; empty = ptrs equal, full = MSBs differ and rest equal.
REQ-013 SHALL write nonce on the clock edge where nonce_valid=1 and not full; count updates the next cycle.
REQ-014 SHALL drop nonce_valid while full, leave FIFO contents unchanged, and set overflow on the same edge.
REQ-015 SHALL run a drain FSM: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-016 IDLE -> SEND when FIFO non-empty and tx_busy=0; tx_word is loaded from the head entry on that edge.
REQ-017 SEND: tx_send=1 for exactly one cycle; next state WAIT_BUSY; tx_word is held.
REQ-018 WAIT_BUSY -> WAIT_DONE when tx_busy=1; the head entry is popped on that edge.
REQ-019 WAIT_BUSY -> IDLE without popping if tx_busy stays 0 for WAIT_LIMIT cycles; the same word is retried later.
REQ-020 WAIT_DONE -> IDLE when tx_busy=0.
REQ-021 Push and pop on the same edge SHALL both take effect and leave count unchanged. This applies when full, since the pop frees the slot.
REQ-022 Latency: a nonce written to an empty FIFO with tx_busy=0 SHALL produce tx_send exactly 2 cycles after its nonce_valid edge.
REQ-023 Pointers SHALL wrap modulo 2**(DEPTH_LOG2+1); ordering is strictly FIFO.
REQ-024 tx_send SHALL never assert while tx_busy=1 is sampled in IDLE.

Reset
REQ-025 On reset=1 at a clock edge: ptrs=0, count=0, overflow=0, tx_send=0, tx_word=0, FSM=IDLE.
REQ-026 Reset SHALL take priority over a simultaneous nonce_valid; that nonce is discarded.
REQ-027 Reset mid-handshake SHALL discard queue contents and the in-flight word; no tx_send for it afterwards.

Configuration
REQ-028 Macro CONFIG_NONCE_DEDUP_EN present: a nonce equal to the most recently accepted nonce SHALL be discarded, not counted as overflow. The last-accepted register resets to 0 with a valid flag of 0.
REQ-029 Macro absent: every nonce_valid is enqueued subject only to full; no comparison logic is built.

Verification
REQ-030 Reset, then nonce_valid with 0xDEADBEEF, tx_busy=0 -> tx_send one cycle at +2 with tx_word=0xDEADBEEF. Model tx_busy high 1 cycle after send, for 40 cycles -> count returns 0.
REQ-031 9 back-to-back nonces 0x1..0x9, DEPTH_LOG2=3, tx_busy held 1 -> count=8, overflow=1. Release busy -> words 0x1..0x8 transmitted in order; 0x9 never sent.
REQ-032 Push on the same edge as the pop at full -> count stays 8, new word is sent last.
REQ-033 tx_busy tied 0 in WAIT_BUSY (transmitter ignores the request) -> return to IDLE after 16 cycles, same word re-sent, count unchanged.
REQ-034 With CONFIG_NONCE_DEDUP_EN, push 0xA, 0xA, 0xB -> 2 words sent, overflow=0. Without the macro -> 3 words sent.
REQ-035 Assert reset in WAIT_DONE with 3 entries queued -> count=0, overflow=0, no further tx_send.
